reg_file_access_ctrl: RTL and testbench

REG_FILE_ACCESS_CTRL -- requirements
Module: reg_file_access_ctrl

---
 rtl/reg_file_access_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_reg_file_access_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_access_ctrl.sv
// reg_file_access_ctrl
// Host-command front end for a 32-entry register file (register 0 reads as
// zero). Accepts one command at a time: a single write, a dual-port read, or
// a clear-all that zeroes registers 1..31 over 31 cycles. All outputs come
// from flops, so nothing from the host ports reaches the register file
// combinationally.
//
// Build option: define READBACK_CHECK_EN to add a VERIFY state. VERIFY reads
// back every write to a nonzero register and sets a sticky error_o if the
// data does not match. In the default build there is no VERIFY state and
// error_o is tied low.
module reg_file_access_ctrl #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic         cmd_write_i,
    input  logic         cmd_clear_i,
    input  logic [4:0]   cmd_addr1_i,
    input  logic [4:0]   cmd_addr2_i,
    input  logic [N-1:0] cmd_data_i,
    output logic         rsp_valid_o,
    output logic [N-1:0] rsp_data1_o,
    output logic [N-1:0] rsp_data2_o,
    output logic         busy_o,
    output logic         error_o,
    output logic         Reg_Write_o,
    output logic [4:0]   Write_Register_o,
    output logic [N-1:0] Write_Data_o,
    output logic [4:0]   Read_Register_1_o,
    output logic [4:0]   Read_Register_2_o,
    input  logic [N-1:0] Read_Data_1_i,
    input  logic [N-1:0] Read_Data_2_i
);

    // FSM encoding (kept as plain constants for legacy tool flows)
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WRITE  = 3'd1;
    localparam logic [2:0] READ   = 3'd2;
    localparam logic [2:0] RESP   = 3'd3;
    localparam logic [2:0] CLEAR  = 3'd4;
`ifdef READBACK_CHECK_EN
    localparam logic [2:0] VERIFY = 3'd5;
`endif

    localparam logic [4:0] LAST_REG = 5'd31;

    // Map an accepted command onto its first state: clear beats write,
    // and write beats read.
    function automatic logic [2:0] decode_cmd(input logic clear_cmd,
                                              input logic write_cmd);
        logic [2:0] first_state;
        if (clear_cmd) begin
            first_state = CLEAR;
        end else if (write_cmd) begin
            first_state = WRITE;
        end else begin
            first_state = READ;
        end
        return first_state;
    endfunction

    // Control state and the latched command
    logic [2:0]   state_q,     state_d;
    logic [4:0]   addr1_q,     addr1_d;
    logic [4:0]   addr2_q,     addr2_d;
    logic [N-1:0] data_q,      data_d;
    logic [4:0]   clr_cnt_q,   clr_cnt_d;
    logic [N-1:0] rsp1_q,      rsp1_d;
    logic [N-1:0] rsp2_q,      rsp2_d;

    // Output flops
    logic         ready_q,     ready_d;
    logic         busy_q,      busy_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic         reg_write_q, reg_write_d;
    logic [4:0]   wr_reg_q,    wr_reg_d;
    logic [N-1:0] wr_data_q,   wr_data_d;
    logic [4:0]   rd_reg1_q,   rd_reg1_d;
    logic [4:0]   rd_reg2_q,   rd_reg2_d;

`ifdef READBACK_CHECK_EN
    logic         error_q,     error_d;
`endif

    // Next-state logic: command acceptance, sequencing and data capture
    always_comb begin
        state_d   = state_q;
        addr1_d   = addr1_q;
        addr2_d   = addr2_q;
        data_d    = data_q;
        clr_cnt_d = clr_cnt_q;
        rsp1_d    = rsp1_q;
        rsp2_d    = rsp2_q;
`ifdef READBACK_CHECK_EN
        error_d   = error_q;
`endif
        case (state_q)
            IDLE: begin
                // ready_q is low in the first cycle after reset, so
                // nothing is accepted until cmd_ready_o is actually high.
                if (cmd_valid_i && ready_q) begin
                    addr1_d = cmd_addr1_i;
                    addr2_d = cmd_addr2_i;
                    data_d  = cmd_data_i;
                    state_d = decode_cmd(cmd_clear_i, cmd_write_i);
                    if (cmd_clear_i) begin
                        clr_cnt_d = 5'd1;
                    end else begin
                        clr_cnt_d = clr_cnt_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
`ifdef READBACK_CHECK_EN
                // Register 0 cannot hold data, so there is nothing to check.
                if (addr1_q != 5'd0) begin
                    state_d = VERIFY;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            READ: begin
                // The register file read path is combinational: the data is
                // valid by the end of the cycle in which the address is driven.
                rsp1_d  = Read_Data_1_i;
                rsp2_d  = Read_Data_2_i;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            CLEAR: begin
                // Stop at the last register rather than letting the counter wrap.
                if (clr_cnt_q == LAST_REG) begin
                    state_d = IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 5'd1;
                end
            end
`ifdef READBACK_CHECK_EN
            VERIFY: begin
                if (Read_Data_1_i != data_q) begin
                    error_d = 1'b1;
                end else begin
                    error_d = error_q;
                end
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state, so the outputs come straight off flops
    always_comb begin
        ready_d     = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == RESP);
        reg_write_d = 1'b0;
        wr_reg_d    = 5'd0;
        wr_data_d   = {N{1'b0}};
        rd_reg1_d   = 5'd0;
        rd_reg2_d   = 5'd0;
        case (state_d)
            WRITE: begin
                // A write to register 0 still takes its cycle but never strobes.
                reg_write_d = (addr1_d != 5'd0);
                wr_reg_d    = addr1_d;
                wr_data_d   = data_d;
            end
            READ: begin
                rd_reg1_d = addr1_d;
                rd_reg2_d = addr2_d;
            end
            CLEAR: begin
                reg_write_d = 1'b1;
                wr_reg_d    = clr_cnt_d;
                wr_data_d   = {N{1'b0}};
            end
`ifdef READBACK_CHECK_EN
            VERIFY: begin
                rd_reg1_d = addr1_d;
            end
`endif
            default: begin
                reg_write_d = 1'b0;
            end
        endcase
    end

    // State, command and output registers; reset aborts any command in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr1_q     <= 5'd0;
            addr2_q     <= 5'd0;
            data_q      <= {N{1'b0}};
            clr_cnt_q   <= 5'd0;
            rsp1_q      <= {N{1'b0}};
            rsp2_q      <= {N{1'b0}};
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            reg_write_q <= 1'b0;
            wr_reg_q    <= 5'd0;
            wr_data_q   <= {N{1'b0}};
            rd_reg1_q   <= 5'd0;
            rd_reg2_q   <= 5'd0;
        end else begin
            state_q     <= state_d;
            addr1_q     <= addr1_d;
            addr2_q     <= addr2_d;
            data_q      <= data_d;
            clr_cnt_q   <= clr_cnt_d;
            rsp1_q      <= rsp1_d;
            rsp2_q      <= rsp2_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            reg_write_q <= reg_write_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
            rd_reg1_q   <= rd_reg1_d;
            rd_reg2_q   <= rd_reg2_d;
        end
    end

`ifdef READBACK_CHECK_EN
    // Sticky readback-mismatch flag; only reset clears it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

    assign cmd_ready_o       = ready_q;
    assign busy_o            = busy_q;
    assign rsp_valid_o       = rsp_valid_q;
    assign rsp_data1_o       = rsp1_q;
    assign rsp_data2_o       = rsp2_q;
    assign Reg_Write_o       = reg_write_q;
    assign Write_Register_o  = wr_reg_q;
    assign Write_Data_o      = wr_data_q;
    assign Read_Register_1_o = rd_reg1_q;
    assign Read_Register_2_o = rd_reg2_q;

endmodule

// File: tb/tb_reg_file_access_ctrl.sv
// Self-checking bench for reg_file_access_ctrl. Includes a behavioural
// 32-entry register file as the environment and a separate reference array
// that holds what each register should contain according to the command rules.
// Also handles the READBACK_CHECK_EN build.
module tb_reg_file_access_ctrl;

    localparam int N = 32;
`ifdef READBACK_CHECK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid_i, cmd_ready_o, cmd_write_i, cmd_clear_i;
    logic [4:0]   cmd_addr1_i, cmd_addr2_i;
    logic [N-1:0] cmd_data_i;
    logic         rsp_valid_o;
    logic [N-1:0] rsp_data1_o, rsp_data2_o;
    logic         busy_o, error_o, Reg_Write_o;
    logic [4:0]   Write_Register_o, Read_Register_1_o, Read_Register_2_o;
    logic [N-1:0] Write_Data_o, Read_Data_1_i, Read_Data_2_i;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_file_access_ctrl #(.N(N)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i), .cmd_clear_i(cmd_clear_i),
        .cmd_addr1_i(cmd_addr1_i), .cmd_addr2_i(cmd_addr2_i), .cmd_data_i(cmd_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data1_o(rsp_data1_o), .rsp_data2_o(rsp_data2_o),
        .busy_o(busy_o), .error_o(error_o),
        .Reg_Write_o(Reg_Write_o), .Write_Register_o(Write_Register_o),
        .Write_Data_o(Write_Data_o), .Read_Register_1_o(Read_Register_1_o),
        .Read_Register_2_o(Read_Register_2_o),
        .Read_Data_1_i(Read_Data_1_i), .Read_Data_2_i(Read_Data_2_i)
    );

    // All outputs in one vector, for the all-zero reset checks
    logic [115:0] outs_s;
    assign outs_s = {cmd_ready_o, busy_o, error_o, rsp_valid_o, rsp_data1_o, rsp_data2_o,
                     Reg_Write_o, Write_Register_o, Write_Data_o,
                     Read_Register_1_o, Read_Register_2_o};

    // Environment register file: combinational read, written at the clock edge
    logic [N-1:0] rf [32] = '{default: 32'h0};
    bit           force_bad5 = 1'b0;
    logic [4:0]   log_addr [$];
    logic [N-1:0] log_data [$];

    always_comb begin
        Read_Data_1_i = rf[Read_Register_1_o];
        if (Read_Register_1_o == 5'd0 || (force_bad5 && Read_Register_1_o == 5'd5))
            Read_Data_1_i = 32'h0;
        Read_Data_2_i = rf[Read_Register_2_o];
        if (Read_Register_2_o == 5'd0)
            Read_Data_2_i = 32'h0;
    end

    always @(posedge clk) begin
        if (Reg_Write_o === 1'b1) begin
            log_addr.push_back(Write_Register_o);
            log_data.push_back(Write_Data_o);
            if (Write_Register_o != 5'd0) rf[Write_Register_o] <= Write_Data_o;
        end
    end

    // Reference contents, updated only from the command rules
    logic [N-1:0] ref_rf [32];

    function automatic int exp_write_busy(input logic [4:0] a);
        return (a != 5'd0 && READBACK) ? 2 : 1;
    endfunction

    // Present a command once the controller is ready; returns 1 time unit after the accept edge
    task automatic issue(input bit clr, input bit wr, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [N-1:0] d, input bit hold);
        int guard;
        guard = 0;
        @(negedge clk);
        while (cmd_ready_o !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: cmd_ready_o=%b, required 1", cmd_ready_o);
        end
        cmd_valid_i = 1'b1; cmd_clear_i = clr; cmd_write_i = wr;
        cmd_addr1_i = a1; cmd_addr2_i = a2; cmd_data_i = d;
        @(posedge clk); #1;
        if (!hold) begin
            // Junk after acceptance must not affect the running command
            cmd_valid_i = 1'b0;
            cmd_clear_i = 1'($urandom); cmd_write_i = 1'($urandom);
            cmd_addr1_i = 5'($urandom); cmd_addr2_i = 5'($urandom);
            cmd_data_i = $urandom;
        end
    endtask

    // Follow the command until busy drops (bounded)
    task automatic observe(output int busy_cyc, output int wr_cyc, output int rsp_lat,
                           output logic [N-1:0] r1, output logic [N-1:0] r2);
        busy_cyc = 0; wr_cyc = 0; rsp_lat = -1; r1 = 32'h0; r2 = 32'h0;
        while (busy_o === 1'b1 && busy_cyc < 100) begin
            if (Reg_Write_o === 1'b1) wr_cyc++;
            if (rsp_valid_o === 1'b1 && rsp_lat < 0) begin
                rsp_lat = busy_cyc + 1;
                r1 = rsp_data1_o; r2 = rsp_data2_o;
            end
            busy_cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (outs_s !== 116'h0) begin
            n_err++; $display("FAIL reset_outputs: got %h, required all zero", outs_s);
        end
        @(negedge clk); reset = 1'b1; #1;
        n_vec++;
        if (cmd_ready_o !== 1'b0) begin
            n_err++; $display("FAIL ready_before_edge: got %b, required 0", cmd_ready_o);
        end
        @(posedge clk); #1;
        n_vec++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL ready_after_edge: ready=%b busy=%b, required 1/0", cmd_ready_o, busy_o);
        end
    endtask

    task automatic test_write_read();
        int b, w, l; logic [N-1:0] r1, r2;
        issue(1'b0, 1'b1, 5'd1, 5'd0, 32'h4DE7E0CD, 1'b0);
        n_vec++;
        if (Reg_Write_o !== 1'b1 || Write_Register_o !== 5'd1 || Write_Data_o !== 32'h4DE7E0CD) begin
            n_err++; $display("FAIL write_strobe: we=%b reg=%0d data=%h, required 1/1/4de7e0cd",
                              Reg_Write_o, Write_Register_o, Write_Data_o);
        end
        observe(b, w, l, r1, r2);
        ref_rf[1] = 32'h4DE7E0CD;
        n_vec++;
        if (w !== 1 || b !== exp_write_busy(5'd1)) begin
            n_err++; $display("FAIL write_pulse: strobes=%0d busy=%0d, required 1/%0d", w, b, exp_write_busy(5'd1));
        end
        issue(1'b0, 1'b0, 5'd1, 5'd1, 32'h0, 1'b0);
        n_vec++;
        if (rsp_valid_o !== 1'b0 || Read_Register_1_o !== 5'd1 || Read_Register_2_o !== 5'd1) begin
            n_err++; $display("FAIL read_cycle: rsp=%b rr1=%0d rr2=%0d, required 0/1/1",
                              rsp_valid_o, Read_Register_1_o, Read_Register_2_o);
        end
        observe(b, w, l, r1, r2);
        n_vec++;
        if (l !== 2 || b !== 2 || r1 !== ref_rf[1] || r2 !== ref_rf[1]) begin
            n_err++; $display("FAIL read_resp: lat=%0d busy=%0d d1=%h d2=%h, required 2/2/%h/%h",
                              l, b, r1, r2, ref_rf[1], ref_rf[1]);
        end
        n_vec++;
        if (rsp_valid_o !== 1'b0 || rsp_data1_o !== 32'h4DE7E0CD) begin
            n_err++; $display("FAIL rsp_one_cycle: rsp=%b d1=%h, required 0/4de7e0cd", rsp_valid_o, rsp_data1_o);
        end
        issue(1'b0, 1'b1, 5'd2, 5'd0, 32'h13572468, 1'b0);
        observe(b, w, l, r1, r2);
        ref_rf[2] = 32'h13572468;
        n_vec++;
        if (rsp_data1_o !== 32'h4DE7E0CD || rsp_data2_o !== 32'h4DE7E0CD) begin
            n_err++; $display("FAIL rsp_hold: d1=%h d2=%h, required 4de7e0cd", rsp_data1_o, rsp_data2_o);
        end
    endtask

    task automatic test_write_r0();
        int b, w, l; logic [N-1:0] r1, r2;
        issue(1'b0, 1'b1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
        observe(b, w, l, r1, r2);
        n_vec++;
        if (w !== 0 || b !== 1) begin
            n_err++; $display("FAIL write_r0: strobes=%0d busy=%0d, required 0/1", w, b);
        end
        issue(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);
        observe(b, w, l, r1, r2);
        n_vec++;
        if (r1 !== 32'h0 || r2 !== 32'h0 || l !== 2) begin
            n_err++; $display("FAIL read_r0: d1=%h d2=%h lat=%0d, required 0/0/2", r1, r2, l);
        end
    endtask

    // Clear (optionally with write also set, and valid held high throughout)
    task automatic run_clear(input bit with_write, input bit hold, input string tag);
        int b, w, l, base; bit seq_ok; logic [N-1:0] r1, r2;
        base = log_addr.size();
        issue(1'b1, with_write, 5'd7, 5'd3, 32'hDEADBEEF, hold);
        observe(b, w, l, r1, r2);
        cmd_valid_i = 1'b0;
        for (int i = 1; i < 32; i++) ref_rf[i] = 32'h0;
        seq_ok = (log_addr.size() == base + 31);
        for (int i = 0; i < 31 && seq_ok; i++)
            if (log_addr[base + i] !== 5'(i + 1) || log_data[base + i] !== 32'h0) seq_ok = 1'b0;
        n_vec++;
        if (w !== 31 || b !== 31 || !seq_ok) begin
            n_err++; $display("FAIL %s: strobes=%0d busy=%0d seq_ok=%0d, required 31/31/1", tag, w, b, seq_ok);
        end
        issue(1'b0, 1'b0, 5'd31, 5'd7, 32'h0, 1'b0);
        observe(b, w, l, r1, r2);
        n_vec++;
        if (r1 !== 32'h0 || r2 !== 32'h0) begin
            n_err++; $display("FAIL %s_readback: d1=%h d2=%h, required 0/0", tag, r1, r2);
        end
    endtask

    task automatic test_clear();
        int b, w, l; logic [N-1:0] r1, r2;
        issue(1'b0, 1'b1, 5'd31, 5'd0, 32'h12345678, 1'b0);
        observe(b, w, l, r1, r2);
        issue(1'b0, 1'b1, 5'd7, 5'd0, 32'h77777777, 1'b0);
        observe(b, w, l, r1, r2);
        run_clear(1'b0, 1'b0, "clear");
    endtask

    task automatic test_priority();
        int b, w, l; logic [N-1:0] r1, r2;
        issue(1'b0, 1'b1, 5'd7, 5'd0, 32'h0BADF00D, 1'b0);
        observe(b, w, l, r1, r2);
        run_clear(1'b1, 1'b1, "clear_over_write");
    endtask

    task automatic test_reset_mid_clear();
        int b, w, l, guard; logic [N-1:0] r1, r2;
        issue(1'b0, 1'b1, 5'd11, 5'd0, 32'hC0FFEE11, 1'b0);
        observe(b, w, l, r1, r2);
        ref_rf[11] = 32'hC0FFEE11;
        issue(1'b0, 1'b1, 5'd10, 5'd0, 32'h00001010, 1'b0);
        observe(b, w, l, r1, r2);
        issue(1'b1, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);
        guard = 0;
        @(negedge clk);
        while (!(Reg_Write_o === 1'b1 && Write_Register_o === 5'd11) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (guard >= 100) begin
            n_err++; $display("FAIL clear_reach_11: reg=%0d, required 11", Write_Register_o);
        end
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) ref_rf[i] = 32'h0;
        #1;
        n_vec++;
        if (outs_s !== 116'h0) begin
            n_err++; $display("FAIL reset_mid_clear: got %h, required all zero", outs_s);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL ready_after_abort: ready=%b busy=%b, required 1/0", cmd_ready_o, busy_o);
        end
        issue(1'b0, 1'b0, 5'd11, 5'd10, 32'h0, 1'b0);
        observe(b, w, l, r1, r2);
        n_vec++;
        if (r1 !== ref_rf[11] || r2 !== ref_rf[10]) begin
            n_err++; $display("FAIL abort_contents: r11=%h r10=%h, required %h/%h", r1, r2, ref_rf[11], ref_rf[10]);
        end
    endtask

    task automatic test_random();
        int b, w, l, op; logic [4:0] a1, a2; logic [N-1:0] d, r1, r2;
        for (int k = 0; k < 60; k++) begin
            op = $urandom_range(0, 19);
            a1 = 5'($urandom); a2 = 5'($urandom); d = $urandom;
            if (op == 0) begin
                run_clear(1'($urandom), 1'b0, "rand_clear");
            end else if (op < 10) begin
                issue(1'b0, 1'b1, a1, a2, d, 1'b0);
                observe(b, w, l, r1, r2);
                if (a1 != 5'd0) ref_rf[a1] = d;
                n_vec++;
                if (b !== exp_write_busy(a1) || w !== ((a1 != 5'd0) ? 1 : 0) ||
                    (a1 != 5'd0 && (log_addr[$] !== a1 || log_data[$] !== d))) begin
                    n_err++; $display("FAIL rand_write[%0d]: reg=%0d busy=%0d strobes=%0d, required busy %0d",
                                      k, a1, b, w, exp_write_busy(a1));
                end
            end else begin
                issue(1'b0, 1'b0, a1, a2, d, 1'b0);
                observe(b, w, l, r1, r2);
                n_vec++;
                if (l !== 2 || b !== 2 || w !== 0 || r1 !== ref_rf[a1] || r2 !== ref_rf[a2]) begin
                    n_err++; $display("FAIL rand_read[%0d]: a=%0d/%0d lat=%0d d=%h/%h, required 2 and %h/%h",
                                      k, a1, a2, l, r1, r2, ref_rf[a1], ref_rf[a2]);
                end
            end
        end
        n_vec++;
        if (error_o !== 1'b0) begin
            n_err++; $display("FAIL error_quiet: got %b, required 0", error_o);
        end
    endtask

`ifdef READBACK_CHECK_EN
    task automatic test_verify();
        int b, w, l; logic [N-1:0] r1, r2;
        force_bad5 = 1'b1;
        issue(1'b0, 1'b1, 5'd5, 5'd0, 32'hA5A5A5A5, 1'b0);
        observe(b, w, l, r1, r2);
        ref_rf[5] = 32'hA5A5A5A5;
        force_bad5 = 1'b0;
        n_vec++;
        if (error_o !== 1'b1 || b !== 2) begin
            n_err++; $display("FAIL verify_mismatch: error=%b busy=%0d, required 1/2", error_o, b);
        end
        issue(1'b0, 1'b1, 5'd6, 5'd0, 32'h66666666, 1'b0);
        observe(b, w, l, r1, r2);
        ref_rf[6] = 32'h66666666;
        n_vec++;
        if (error_o !== 1'b1) begin
            n_err++; $display("FAIL verify_sticky: error=%b, required 1", error_o);
        end
        @(negedge clk); reset = 1'b0; #1;
        n_vec++;
        if (error_o !== 1'b0) begin
            n_err++; $display("FAIL verify_reset: error=%b, required 0", error_o);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_clear_i = 1'b0;
        cmd_addr1_i = 5'd0; cmd_addr2_i = 5'd0; cmd_data_i = 32'h0;
        for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
        test_reset();
        test_write_read();
        test_write_r0();
        test_clear();
        test_priority();
        test_reset_mid_clear();
        test_random();
`ifdef READBACK_CHECK_EN
        test_verify();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
